// File: rtl/jk_bank_scheduler.sv
// Round-robin scheduler that shares one JK flip-flop bank between two requesters
// and sequences each accepted command into registered J/K drive vectors.
module jk_bank_scheduler #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_mask,
  input  logic [CNT_W-1:0] req0_len,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_mask,
  input  logic [CNT_W-1:0] req1_len,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             grant_id,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_BURST = 2'b11;

  state_t           state_q;
  logic [WIDTH-1:0] j_q, k_q;
  logic [WIDTH-1:0] j_d, k_d;
  logic [CNT_W-1:0] cnt_q;
  logic             grant_q, last_q, done_q;

  logic             idle;
  logic             accept;
  logic             sel;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_mask;
  logic [CNT_W-1:0] sel_len;

  assign idle = (state_q == IDLE);

  // last_q==1 means requester 0 has priority on the next contended cycle
  assign req0_ready = idle & req0_valid & (~req1_valid | last_q);
  assign req1_ready = idle & req1_valid & (~req0_valid | ~last_q);

  assign accept   = req0_ready | req1_ready;
  assign sel      = req1_ready;
  assign sel_op   = sel ? req1_op   : req0_op;
  assign sel_mask = sel ? req1_mask : req0_mask;
  assign sel_len  = sel ? req1_len  : req0_len;

  always_comb begin
    j_d = sel_mask;
    k_d = sel_mask;
    case (sel_op)
      OP_CLEAR: j_d = '0;
      OP_SET:   k_d = '0;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      j_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            j_q     <= j_d;
            k_q     <= k_d;
            cnt_q   <= sel_len;
            grant_q <= sel;
            last_q  <= sel;
            if (sel_op == OP_BURST) begin
              state_q <= BURST;
              done_q  <= (sel_len == '0);
            end else begin
              state_q <= ISSUE;
              done_q  <= 1'b1;
            end
          end else begin
            done_q <= 1'b0;
          end
        end
        ISSUE: begin
          j_q     <= '0;
          k_q     <= '0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        BURST: begin
          if (cnt_q == '0) begin
            j_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            // done lands in the cycle where the counter reads zero
            cnt_q  <= cnt_q - 1'b1;
            done_q <= (cnt_q == CNT_W'(1));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign j_out    = j_q;
  assign k_out    = k_q;
  assign busy     = ~idle;
  assign grant_id = grant_q;
  assign done     = done_q;

endmodule

// File: tb/tb_jk_bank_scheduler.sv
// Table-driven bench for jk_bank_scheduler with a per-cycle drive scoreboard.
module tb_jk_bank_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_op, req1_op;
  logic [3:0] req0_mask, req1_mask;
  logic [3:0] req0_len, req1_len;
  logic [3:0] j_out, k_out;
  logic       busy, grant_id, done;

  jk_bank_scheduler #(.WIDTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_mask(req0_mask), .req0_len(req0_len),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_mask(req1_mask), .req1_len(req1_len),
    .j_out(j_out), .k_out(k_out), .busy(busy), .grant_id(grant_id), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v0; logic [1:0] op0; logic [3:0] m0; logic [3:0] l0;
    bit v1; logic [1:0] op1; logic [3:0] m1; logic [3:0] l1;
    bit eg; logic [3:0] ej; logic [3:0] ek; int ncyc; int gap;
  } vec_t;

  typedef struct {
    logic [3:0] j; logic [3:0] k; bit d; bit g;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[12];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare the current drive against the scoreboard head; idle must drive zeros.
  task automatic monitor();
    exp_t e;
    if (busy === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("j_out", 32'(j_out), 32'(e.j));
        chk("k_out", 32'(k_out), 32'(e.k));
        chk("done", 32'(done), 32'(e.d));
        chk("grant_id", 32'(grant_id), 32'(e.g));
      end
    end else begin
      chk("idle_j", 32'(j_out), 32'd0);
      chk("idle_k", 32'(k_out), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic push_cmd(input logic [3:0] j, input logic [3:0] k, input int n, input bit g, input bit last_done);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.j = j; e.k = k; e.g = g;
      e.d = last_done && (i == n - 1);
      sbq.push_back(e);
    end
  endtask

  function automatic vec_t mkv(input bit v0, input logic [1:0] op0, input logic [3:0] m0, input logic [3:0] l0,
                               input bit v1, input logic [1:0] op1, input logic [3:0] m1, input logic [3:0] l1,
                               input bit eg, input logic [3:0] ej, input logic [3:0] ek, input int ncyc, input int gap);
    vec_t v;
    v.v0 = v0; v.op0 = op0; v.m0 = m0; v.l0 = l0;
    v.v1 = v1; v.op1 = op1; v.m1 = m1; v.l1 = l1;
    v.eg = eg; v.ej = ej; v.ek = ek; v.ncyc = ncyc; v.gap = gap;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    bit accepted = 0;
    logic win_rdy, lose_rdy;
    req0_valid = v.v0; req0_op = v.op0; req0_mask = v.m0; req0_len = v.l0;
    req1_valid = v.v1; req1_op = v.op1; req1_mask = v.m1; req1_len = v.l1;
    #1;
    for (int w = 0; w < 40 && !accepted; w++) begin
      if (busy === 1'b1) begin
        chk("ready0_busy", 32'(req0_ready), 32'd0);
        chk("ready1_busy", 32'(req1_ready), 32'd0);
        tick();
      end else begin
        win_rdy  = v.eg ? req1_ready : req0_ready;
        lose_rdy = v.eg ? req0_ready : req1_ready;
        chk("winner_ready", 32'(win_rdy), 32'd1);
        chk("loser_ready", 32'(lose_rdy), 32'd0);
        if (win_rdy === 1'b1) begin
          push_cmd(v.ej, v.ek, v.ncyc, v.eg, 1'b1);
          tick();
          accepted = 1;
          if (v.gap != 0) chk("accept_gap", 32'(cyc - last_acc), 32'(v.gap));
          last_acc = cyc;
          if (v.eg) req1_valid = 1'b0; else req0_valid = 1'b0;
        end else begin
          tick();
        end
      end
    end
    if (!accepted) begin
      $display("FAIL accept_timeout: vector %0d got no accept expected accept", idx);
      fails++;
      tests++;
    end
    $display("[TB] vec %0d grant=%0d j=%b k=%b cycles=%0d", idx, v.eg, v.ej, v.ek, v.ncyc);
  endtask

  initial begin
    vec_t rv;
    rst = 1'b1;
    req0_valid = 0; req0_op = 0; req0_mask = 0; req0_len = 0;
    req1_valid = 0; req1_op = 0; req1_mask = 0; req1_len = 0;

    vecs[0]  = mkv(1, 2'b01, 4'b0101, 0,  0, 2'b00, 4'b0000, 0,  0, 4'b0101, 4'b0000, 1, 0);
    vecs[1]  = mkv(1, 2'b10, 4'b1111, 0,  1, 2'b10, 4'b1111, 0,  1, 4'b1111, 4'b1111, 1, 2);
    vecs[2]  = mkv(1, 2'b10, 4'b1111, 0,  1, 2'b10, 4'b1111, 0,  0, 4'b1111, 4'b1111, 1, 2);
    vecs[3]  = mkv(1, 2'b10, 4'b1111, 0,  1, 2'b10, 4'b1111, 0,  1, 4'b1111, 4'b1111, 1, 2);
    vecs[4]  = mkv(1, 2'b10, 4'b1111, 0,  1, 2'b10, 4'b1111, 0,  0, 4'b1111, 4'b1111, 1, 2);
    vecs[5]  = mkv(0, 2'b00, 4'b0000, 0,  1, 2'b11, 4'b0011, 3,  1, 4'b0011, 4'b0011, 4, 0);
    vecs[6]  = mkv(0, 2'b00, 4'b0000, 0,  1, 2'b11, 4'b1000, 0,  1, 4'b1000, 4'b1000, 1, 0);
    vecs[7]  = mkv(1, 2'b00, 4'b1010, 0,  0, 2'b00, 4'b0000, 0,  0, 4'b0000, 4'b1010, 1, 0);
    vecs[8]  = mkv(0, 2'b00, 4'b0000, 0,  1, 2'b10, 4'b0110, 0,  1, 4'b0110, 4'b0110, 1, 0);
    vecs[9]  = mkv(1, 2'b11, 4'b1100, 15, 0, 2'b00, 4'b0000, 0,  0, 4'b1100, 4'b1100, 16, 0);
    vecs[10] = mkv(1, 2'b00, 4'b0000, 0,  1, 2'b11, 4'b1001, 2,  1, 4'b1001, 4'b1001, 3, 0);
    vecs[11] = mkv(1, 2'b00, 4'b0000, 0,  0, 2'b00, 4'b0000, 0,  0, 4'b0000, 4'b0000, 1, 0);

    tick();
    tick();
    chk("rst_j", 32'(j_out), 32'd0);
    chk("rst_k", 32'(k_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    $display("[TB] reset checked");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Drain, then abort a long burst with reset in its third drive cycle.
    for (int w = 0; w < 40 && busy === 1'b1; w++) tick();
    req0_valid = 1; req0_op = 2'b11; req0_mask = 4'b1111; req0_len = 4'd15;
    req1_valid = 0;
    #1;
    chk("rb_ready0", 32'(req0_ready), 32'd1);
    push_cmd(4'b1111, 4'b1111, 3, 1'b0, 1'b0);
    tick();
    req0_valid = 0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rb_busy", 32'(busy), 32'd0);
    chk("rb_j", 32'(j_out), 32'd0);
    chk("rb_k", 32'(k_out), 32'd0);
    rst = 1'b0;
    $display("[TB] reset mid-burst checked");
    rv = mkv(1, 2'b01, 4'b0110, 0, 1, 2'b01, 4'b0110, 0, 0, 4'b0110, 4'b0000, 1, 0);
    run_vec(rv, 12);
    req0_valid = 0; req1_valid = 0;

    for (int w = 0; w < 40 && busy === 1'b1; w++) tick();
    tick();
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jk_bank_scheduler.md
Name: jk_bank_scheduler

Overview:
- Shares one external WIDTH-bit bank of JK flip-flops between two command requesters (port 0, port 1).
- Arbitrates round-robin between the requesters and accepts commands over valid/ready.
- Sequences each accepted command into registered J/K drive vectors, including multi-cycle toggle bursts.
- Sits between control logic and the JK flip-flop bank; the bank is clocked on the same clk.

Parameters:
WIDTH, 4, number of JK flip-flops in the bank (width of mask, j_out, k_out)
CNT_W, 4, width of burst length field

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset, sampled on rising edge of clk
req0_valid  input  1  requester 0 has a command
req0_ready  output  1  requester 0 command accepted this cycle (when valid also high)
req0_op  input  2  requester 0 opcode
req0_mask  input  WIDTH  requester 0 bit-select mask
req0_len  input  CNT_W  requester 0 burst length minus one
req1_valid  input  1  requester 1 has a command
req1_ready  output  1  requester 1 accept
req1_op  input  2  requester 1 opcode
req1_mask  input  WIDTH  requester 1 mask
req1_len  input  CNT_W  requester 1 burst length minus one
j_out  output  WIDTH  registered J drive to bank
k_out  output  WIDTH  registered K drive to bank
busy  output  1  high in ISSUE or BURST
grant_id  output  1  requester owning current/last command
done  output  1  one-cycle pulse in final drive cycle of a command

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, j_out=0, k_out=0, busy=0, done=0, grant_id=0, last_grant=1, burst counter=0. Reset overrides any in-flight command; outputs are zero from the edge after rst is sampled.
- Opcodes:
  - 00 CLEAR: j=0, k=mask, 1 cycle.
  - 01 SET: j=mask, k=0, 1 cycle.
  - 10 TOGGLE: j=k=mask, 1 cycle.
  - 11 BURST: j=k=mask for len+1 consecutive cycles. len=0 gives 1 cycle; len=2^CNT_W-1 gives 2^CNT_W cycles.
- Unmasked bits always get j=k=0 (hold).
- Arbitration (combinational, IDLE only):
  - req0_ready = idle & req0_valid & (!req1_valid | last_grant==1).
  - req1_ready = idle & req1_valid & (!req0_valid | last_grant==0).
  - At most one ready high per cycle. Ready is 0 outside IDLE. ready may depend on valid.
- Accept: valid & ready at edge.
  - Latch op, mask, and len into the burst counter.
  - Set grant_id and last_grant to the winner.
  - Go to ISSUE (ops 00/01/10) or BURST (op 11).
- j_out/k_out update on the accept edge: drive is visible in cycle t+1 after acceptance in cycle t.
- ISSUE: one cycle. done=1, busy=1. Next edge: j_out=k_out=0, state=IDLE.
- BURST:
  - busy=1, counter decrements each edge.
  - done=1 in the cycle where counter==0. Next edge: j_out=k_out=0, state=IDLE.
- Throughput: minimum 2 cycles per single-cycle command, because ready is 0 during ISSUE and an IDLE cycle with zero drive always separates commands.
- Inputs are ignored while busy. Requester must hold valid and fields stable until ready.
- mask=0: command is still accepted and sequenced normally. Drive is all-zero, done still pulses.
- grant_id holds its value in IDLE.
- done is registered, high exactly one cycle per command.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no valids -> j_out=k_out=0, busy=0, done=0, readies 0.
- Single SET: req0 op=01 mask=4'b0101 -> req0_ready=1 one cycle; next cycle j_out=0101, k_out=0000, done=1, grant_id=0; following cycle zeros, busy=0.
- Contention round-robin: both valid continuously with op=10 mask=1111 -> grants alternate 0,1,0,1 (req0 first after reset), with an accept every 2 cycles.
- Burst length: req1 op=11 mask=0011 len=3 -> j_out=k_out=0011 for exactly 4 cycles, done high only in the 4th, busy high 4 cycles; len=0 -> 1 cycle.
- Reset mid-burst: op=11 len=15, assert rst in 3rd burst cycle -> outputs 0 from next edge, state IDLE, next contended grant goes to req0.
- Busy blocking: req0 valid during req1 burst -> req0_ready stays 0 until IDLE, then accepted; mask=0 CLEAR -> accepted, zero drive, done pulses once.
